// File: rtl/dff_pkg.sv
// Shared constants and helpers for the registered delay line.
package dff_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // Fill counter width: enough to hold 0..depth, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One enabled, clearable data+valid register stage of the delay line.
module dff_stage
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    input  logic             vld_in,
    output logic [WIDTH-1:0] q,
    output logic             vld_out
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    // Clear beats enable; otherwise hold.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (sclr) begin
            data_d = RESET_VAL;
            vld_d  = 1'b0;
        end else if (en) begin
            data_d = d;
            vld_d  = vld_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q       = data_q;
    assign vld_out = vld_q;

endmodule

// File: rtl/dff_delay_line.sv
// WIDTH-bit, DEPTH-stage delay line with enable, sync clear, valid tracking and fill count.
module dff_delay_line
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned       DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      sclr,
    input  logic [WIDTH-1:0]          d,
    input  logic                      vld_in,
    output logic [WIDTH-1:0]          q,
    output logic                      vld_out,
    output logic                      primed,
    output logic [cnt_w(DEPTH)-1:0]   fill_cnt
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_delay_line: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("dff_delay_line: WIDTH must be >= 1");
    end

    // Entry 0 is the input; entry i is the output of stage i-1.
    logic [WIDTH-1:0] data_chain [DEPTH+1];
    logic [DEPTH:0]   vld_chain;

    assign data_chain[0] = d;
    assign vld_chain[0]  = vld_in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .sclr    (sclr),
            .d       (data_chain[i]),
            .vld_in  (vld_chain[i]),
            .q       (data_chain[i+1]),
            .vld_out (vld_chain[i+1])
        );
    end

    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             primed_q, primed_d;

    // Saturating count of advancing edges; primed tracks the next count so it stays a flop.
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        if (sclr) begin
            fill_cnt_d = '0;
        end else if (en && (fill_cnt_q != CNT_W'(DEPTH))) begin
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end
        primed_d = (fill_cnt_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q <= '0;
            primed_q   <= 1'b0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            primed_q   <= primed_d;
        end
    end

    assign q        = data_chain[DEPTH];
    assign vld_out  = vld_chain[DEPTH];
    assign fill_cnt = fill_cnt_q;
    assign primed   = primed_q;

endmodule

// File: tb/tb_dff_delay_line.sv
// Directed self-checking bench for dff_delay_line (WIDTH=8, DEPTH=4, RESET_VAL=0).
module tb_dff_delay_line;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             sclr;
    logic [WIDTH-1:0] d;
    logic             vld_in;
    logic [WIDTH-1:0] q;
    logic             vld_out;
    logic             primed;
    logic [2:0]       fill_cnt;

    int checks   = 0;
    int failures = 0;

    dff_delay_line #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sclr     (sclr),
        .d        (d),
        .vld_in   (vld_in),
        .q        (q),
        .vld_out  (vld_out),
        .primed   (primed),
        .fill_cnt (fill_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; sclr = 1'b0; d = 8'hFF; vld_in = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (q !== 8'h00 || vld_out !== 1'b0 || fill_cnt !== 3'd0 || primed !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc%0d: q=%h vld=%b fill=%0d primed=%b, want q=00 vld=0 fill=0 primed=0",
                         c, q, vld_out, fill_cnt, primed);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        logic [7:0] exp_q;
        logic [2:0] exp_f;
        en = 1'b1; sclr = 1'b0; vld_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            d = 8'(k);
            step();
            exp_q = (k >= 4) ? 8'(k - 3) : 8'h00;
            exp_f = (k >= 4) ? 3'd4 : 3'(k);
            checks++;
            if (q !== exp_q || vld_out !== (k >= 4) || fill_cnt !== exp_f || primed !== (k >= 4)) begin
                failures++;
                $display("FAIL stream edge%0d: q=%h vld=%b fill=%0d primed=%b, want q=%h vld=%b fill=%0d primed=%b",
                         k, q, vld_out, fill_cnt, primed, exp_q, (k >= 4), exp_f, (k >= 4));
            end
        end
    endtask

    task automatic test_enable_gaps();
        sclr = 1'b1; en = 1'b0; step(); sclr = 1'b0;
        en = 1'b1; d = 8'hA5; vld_in = 1'b1; step();
        en = 1'b0; d = 8'h33;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (q !== 8'h00 || vld_out !== 1'b0 || fill_cnt !== 3'd1) begin
                failures++;
                $display("FAIL gap cyc%0d: q=%h vld=%b fill=%0d, want q=00 vld=0 fill=1",
                         c, q, vld_out, fill_cnt);
            end
        end
        en = 1'b1; d = 8'h5A; vld_in = 1'b1; step();
        d = 8'h00; vld_in = 1'b0; step();
        checks++;
        if (q !== 8'h00 || fill_cnt !== 3'd3) begin
            failures++;
            $display("FAIL gap_early: q=%h fill=%0d, want q=00 fill=3", q, fill_cnt);
        end
        step();
        checks++;
        if (q !== 8'hA5 || vld_out !== 1'b1 || fill_cnt !== 3'd4 || primed !== 1'b1) begin
            failures++;
            $display("FAIL gap_a5: q=%h vld=%b fill=%0d primed=%b, want q=a5 vld=1 fill=4 primed=1",
                     q, vld_out, fill_cnt, primed);
        end
        step();
        checks++;
        if (q !== 8'h5A || vld_out !== 1'b1) begin
            failures++;
            $display("FAIL gap_5a: q=%h vld=%b, want q=5a vld=1", q, vld_out);
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] pat_d [4];
        logic       pat_v [4];
        logic [7:0] exp_q;
        logic       exp_v;
        pat_d[0] = 8'h10; pat_d[1] = 8'h11; pat_d[2] = 8'h12; pat_d[3] = 8'h13;
        pat_v[0] = 1'b1;  pat_v[1] = 1'b0;  pat_v[2] = 1'b1;  pat_v[3] = 1'b1;
        sclr = 1'b1; step(); sclr = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4) begin
                d = pat_d[k-1]; vld_in = pat_v[k-1];
            end else begin
                d = 8'h00; vld_in = 1'b0;
            end
            step();
            exp_q = 8'h00; exp_v = 1'b0;
            if (k >= 4 && k <= 7) begin
                exp_q = pat_d[k-4]; exp_v = pat_v[k-4];
            end
            checks++;
            if (q !== exp_q || vld_out !== exp_v) begin
                failures++;
                $display("FAIL bubble edge%0d: q=%h vld=%b, want q=%h vld=%b",
                         k, q, vld_out, exp_q, exp_v);
            end
        end
    endtask

    task automatic test_clear_priority();
        checks++;
        if (primed !== 1'b1 || fill_cnt !== 3'd4) begin
            failures++;
            $display("FAIL clr_pre: primed=%b fill=%0d, want primed=1 fill=4", primed, fill_cnt);
        end
        sclr = 1'b1; en = 1'b1; d = 8'h77; vld_in = 1'b1;
        step();
        checks++;
        if (q !== 8'h00 || vld_out !== 1'b0 || fill_cnt !== 3'd0 || primed !== 1'b0) begin
            failures++;
            $display("FAIL clr_edge: q=%h vld=%b fill=%0d primed=%b, want q=00 vld=0 fill=0 primed=0",
                     q, vld_out, fill_cnt, primed);
        end
        sclr = 1'b0; d = 8'h00; vld_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (q !== 8'h00 || vld_out !== 1'b0) begin
                failures++;
                $display("FAIL clr_drain%0d: q=%h vld=%b, want q=00 vld=0", c, q, vld_out);
            end
        end
    endtask

    task automatic test_async_reset();
        sclr = 1'b0; en = 1'b1; vld_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = 8'(8'h20 + k);
            step();
        end
        checks++;
        if (q !== 8'h20 || vld_out !== 1'b1 || primed !== 1'b1) begin
            failures++;
            $display("FAIL arst_full: q=%h vld=%b primed=%b, want q=20 vld=1 primed=1", q, vld_out, primed);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || vld_out !== 1'b0 || fill_cnt !== 3'd0 || primed !== 1'b0) begin
            failures++;
            $display("FAIL arst_mid: q=%h vld=%b fill=%0d primed=%b, want q=00 vld=0 fill=0 primed=0",
                     q, vld_out, fill_cnt, primed);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = 8'(8'h30 + k);
            step();
            if (k == 2) begin
                checks++;
                if (q !== 8'h00 || fill_cnt !== 3'd3) begin
                    failures++;
                    $display("FAIL arst_refill3: q=%h fill=%0d, want q=00 fill=3", q, fill_cnt);
                end
            end
        end
        checks++;
        if (q !== 8'h30 || vld_out !== 1'b1 || fill_cnt !== 3'd4 || primed !== 1'b1) begin
            failures++;
            $display("FAIL arst_refill4: q=%h vld=%b fill=%0d primed=%b, want q=30 vld=1 fill=4 primed=1",
                     q, vld_out, fill_cnt, primed);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_enable_gaps();
        test_bubbles();
        test_clear_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_delay_line.md
# dff_delay_line

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage registered delay line with clock enable, synchronous clear, per-stage valid tracking and a fill counter. It delays data samples by a fixed number of enabled clock cycles. It serves as the standard pipeline-balancing and retiming element in datapaths.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1); latency in enabled cycles
- RESET_VAL, 0, value loaded into every data stage on reset or clear (WIDTH bits)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  clock enable; the line advances only when high
- sclr  input  1  synchronous clear
- d  input  WIDTH  data in
- vld_in  input  1  marks d as a valid sample
- q  output  WIDTH  data out (last stage)
- vld_out  output  1  valid bit of last stage
- primed  output  1  high once DEPTH enabled cycles have elapsed since reset or clear
- fill_cnt  output  $clog2(DEPTH+1)  enabled cycles since reset or clear, saturating at DEPTH

## Operation
- Reset (rst_n=0, asynchronous): all data stages take RESET_VAL, all valid bits 0, fill_cnt 0, primed 0. Takes effect immediately, without waiting for clk, and overrides everything.
- Priority on each rising edge: sclr > en > hold.
- sclr=1: all data stages take RESET_VAL, valids 0, fill_cnt 0, regardless of en, d and vld_in.
- en=1, sclr=0 (advance):
  - stage0 <= d, vld0 <= vld_in
  - stage i <= stage i-1, for i = 1..DEPTH-1; valid bits shift in lockstep
  - fill_cnt <= min(fill_cnt+1, DEPTH)
- en=0, sclr=0: all state holds, including fill_cnt.
- q = stage DEPTH-1 and vld_out = vld DEPTH-1, both straight from flops with no combinational path from inputs.
- primed = (fill_cnt == DEPTH), a registered-equivalent decode of the counter.
- Data stages advance on en regardless of vld_in. A bubble (vld_in=0) still shifts d through, with its valid bit 0.
- DEPTH=1 degenerates to a single enabled, clearable D flip-flop with a valid bit; fill_cnt is 1 bit.

## Timing
- Latency: a sample presented with en=1 at edge k appears on q after the DEPTH-th enabled edge counted from k inclusive. With en held high, that is DEPTH cycles. Disabled cycles stretch the latency one-for-one.
- fill_cnt increments on every advancing edge until it reaches DEPTH, then saturates and never wraps. primed rises on the same edge on which fill_cnt reaches DEPTH.
- sclr and en high together: the clear wins, so fill_cnt becomes 0, not 1, and d is discarded.
- rst_n deasserting: the first edge that can capture data is the first rising clk with rst_n=1. Deassertion is assumed synchronised upstream.
- Reset asserted mid-stream: q, vld_out, fill_cnt and primed go to reset values within the same delta, with no clock edge needed.

## Structure
- Shared package dff_pkg:
  - helper function for counter width ($clog2(DEPTH+1), with a minimum of 1)
  - default WIDTH and DEPTH constants
- Sub-module dff_stage (WIDTH, RESET_VAL):
  - one enabled, clearable data+valid register with async active-low reset
  - dff_delay_line instantiates DEPTH of them in a generate loop and adds the fill counter and primed decode.
- Parameter checks (DEPTH>=1, WIDTH>=1) are elaboration-time assertions.

## Test plan
- Reset: rst_n=0 for 5 cycles with d=8'hFF and en=1 -> q=8'h00, vld_out=0, fill_cnt=0 and primed=0 throughout.
- Streaming, DEPTH=4: en=1 continuously, d=1,2,3,… with vld_in=1 from edge 0 -> q=1 with vld_out=1 after the 4th edge; primed and fill_cnt=4 rise on that same edge; fill_cnt then stays at 4.
- Enable gaps: stream 8'hA5 then 8'h5A, dropping en for 3 cycles between them -> q and fill_cnt freeze during the gap; 8'hA5 emerges after 4 enabled edges, i.e. 7 clock cycles.
- Bubbles: vld_in pattern 1,0,1,1 with en=1 -> vld_out shows 1,0,1,1 starting 4 cycles later, aligned with data.
- Clear priority: primed line, then sclr=1 and en=1 on the same edge with d=8'h77 -> next cycle q=RESET_VAL, vld_out=0, fill_cnt=0, primed=0; 8'h77 never appears on q.
- Async reset mid-stream: pulse rst_n low between clock edges while full -> outputs reach reset values before the next edge; refilling afterwards restores 4-cycle latency.
